// File: rtl/systolic_pkg.sv
// Constants and helpers shared by the systolic feeder and the drain-side blocks.
package systolic_pkg;

    localparam int DEFAULT_DEPTH      = 4;
    localparam int DEFAULT_FIFO_DEPTH = 8;

    // Ceiling log2, never below 1 so a single-bit pointer still exists.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

    function automatic int result_width(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/systolic_result_fifo.sv
// Registered synchronous FIFO (no bypass) holding finished column results.
module systolic_result_fifo
    import systolic_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = DEFAULT_FIFO_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push_i,
    input  logic [DATA_W-1:0]         data_i,
    input  logic                      pop_i,
    output logic [DATA_W-1:0]         data_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [clog2(DEPTH):0]     count_o
);

    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic do_push;
    logic do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == DEPTH_C);
    assign count_o = count_q;

    // A full FIFO still accepts a push when the same edge pops the head.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Masking keeps the stale, unreset storage from leaking onto the output.
    assign data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; occupancy lives in count_q, so old contents are never observed.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/systolic_drain.sv
// Output-end collector for a chain of systolic_slice stages: token tracking, result FIFO, credit.
// Optional statistics counters are enabled with `define SYSTOLIC_DRAIN_STATS_EN.
module systolic_drain
    import systolic_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      issue_valid,
    input  logic signed [2*WIDTH-1:0] y_in,
    output logic                      can_issue,
    output logic signed [2*WIDTH-1:0] out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      overflow
`ifdef SYSTOLIC_DRAIN_STATS_EN
    ,
    output logic [15:0]               drop_count,
    output logic [15:0]               result_count
`endif
);

    localparam int RES_W = result_width(WIDTH);
    localparam int CW    = clog2(FIFO_DEPTH) + 1;
    localparam int IW    = clog2(DEPTH + 1);

    logic [DEPTH-1:0] tok_q, tok_d;
    logic             overflow_q, overflow_d;
    logic [IW-1:0]    inflight;

    logic             capture;
    logic             pop;
    logic             drop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic [RES_W-1:0] fifo_data;

    // The last token marks the edge at which this column's sum leaves the final slice.
    assign capture = tok_q[DEPTH-1];
    assign pop     = out_valid && out_ready;
    assign drop    = capture && fifo_full && !pop;

    systolic_result_fifo #(
        .DATA_W (RES_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (capture),
        .data_i  (y_in),
        .pop_i   (pop),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_data;
    assign overflow  = overflow_q;

    always_comb begin
        tok_d    = '0;
        tok_d[0] = issue_valid;
        for (int k = 1; k < DEPTH; k++) tok_d[k] = tok_q[k-1];
    end

    always_comb begin
        inflight = '0;
        for (int k = 0; k < DEPTH; k++) inflight = inflight + IW'(tok_q[k]);
    end

    // Conservative credit: assumes nothing drains before the in-flight columns land.
    assign can_issue = (int'(fifo_count) + int'(inflight)) < FIFO_DEPTH;

    assign overflow_d = overflow_q || drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tok_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            tok_q      <= tok_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef SYSTOLIC_DRAIN_STATS_EN
    logic [15:0] drop_count_q, drop_count_d;
    logic [15:0] result_count_q, result_count_d;

    always_comb begin
        drop_count_d   = drop_count_q;
        result_count_d = result_count_q;
        if (drop && (drop_count_q != 16'hFFFF)) drop_count_d = drop_count_q + 16'd1;
        if (pop) result_count_d = result_count_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count_q   <= '0;
            result_count_q <= '0;
        end else begin
            drop_count_q   <= drop_count_d;
            result_count_q <= result_count_d;
        end
    end

    assign drop_count   = drop_count_q;
    assign result_count = result_count_q;
`endif

endmodule

// File: tb/tb_systolic_drain.sv
// Directed self-checking bench for systolic_drain (WIDTH=8, DEPTH=4, FIFO_DEPTH=4).
module tb_systolic_drain;

    localparam int WIDTH      = 8;
    localparam int DEPTH      = 4;
    localparam int FIFO_DEPTH = 4;

    logic                      clk;
    logic                      rst;
    logic                      issue_valid;
    logic signed [2*WIDTH-1:0] y_in;
    logic                      can_issue;
    logic signed [2*WIDTH-1:0] out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic                      overflow;
`ifdef SYSTOLIC_DRAIN_STATS_EN
    logic [15:0]               drop_count;
    logic [15:0]               result_count;
`endif

    int n_vec;
    int n_bad;

    systolic_drain #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .y_in         (y_in),
        .can_issue    (can_issue),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .overflow     (overflow)
`ifdef SYSTOLIC_DRAIN_STATS_EN
        ,
        .drop_count   (drop_count),
        .result_count (result_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        issue_valid = 1'b0;
        out_ready   = 1'b0;
        y_in        = '0;
        rst         = 1'b1;
        #3;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_can_issue", 32'(can_issue), 1);
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    function automatic logic signed [15:0] ydrv(input int s);
        return 16'(s * 37 - 300);
    endfunction

    int vals2 [4] = '{-5, 7, 1000, -32768};
    int vals4 [5] = '{11, 22, 33, 44, 55};
    int exp_q [$];
    int delivered;

    initial begin
        n_vec = 0;
        n_bad = 0;
        issue_valid = 1'b0;
        out_ready   = 1'b0;
        y_in        = '0;
        rst         = 1'b1;
        #12;
        do_reset();

        // Single issue, captured four edges later, popped the edge after.
        issue_valid = 1'b1;
        step();
        issue_valid = 1'b0;
        step();
        step();
        step();
        check("t1_not_yet", 32'(out_valid), 0);
        y_in = 16'sd300;
        step();
        check("t1_valid", 32'(out_valid), 1);
        check("t1_data", 32'(out_data), 300);
        out_ready = 1'b1;
        step();
        check("t1_popped", 32'(out_valid), 0);
        out_ready = 1'b0;

        // Four back-to-back issues fill the FIFO; credit drops after the fourth.
        for (int i = 0; i < 8; i++) begin
            issue_valid = (i < 4);
            if (i >= 4) y_in = 16'(vals2[i-4]);
            step();
            if (i == 2) check("t2_credit_3", 32'(can_issue), 1);
            if (i >= 3) check("t2_no_credit", 32'(can_issue), 0);
        end
        issue_valid = 1'b0;
        check("t2_head", 32'(out_data), -5);
        check("t2_overflow", 32'(overflow), 0);

        // Fifth column lands on a full FIFO with no pop: dropped.
        for (int j = 0; j < 5; j++) begin
            issue_valid = (j == 0);
            if (j == 4) y_in = 16'sd1234;
            step();
        end
        issue_valid = 1'b0;
        check("t3_overflow", 32'(overflow), 1);
        check("t3_head", 32'(out_data), -5);
`ifdef SYSTOLIC_DRAIN_STATS_EN
        check("t3_drop_count", 32'(drop_count), 1);
`endif
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            check("t3_drain", 32'(out_data), 32'(vals2[j]));
            step();
        end
        check("t3_empty", 32'(out_valid), 0);
        check("t3_overflow_sticky", 32'(overflow), 1);
`ifdef SYSTOLIC_DRAIN_STATS_EN
        check("t3_result_count", 32'(result_count), 5);
`endif
        do_reset();

        // Full FIFO with a capture coinciding with a pop: both take effect.
        for (int i = 0; i < 9; i++) begin
            issue_valid = (i < 5);
            if (i >= 4) y_in = 16'(vals4[i-4]);
            out_ready = (i == 8);
            step();
        end
        issue_valid = 1'b0;
        check("t4_overflow", 32'(overflow), 0);
        check("t4_still_full", 32'(can_issue), 0);
        for (int j = 1; j < 5; j++) begin
            check("t4_drain", 32'(out_data), 32'(vals4[j]));
            step();
        end
        check("t4_empty", 32'(out_valid), 0);
        out_ready = 1'b0;
        do_reset();

        // Asynchronous reset with one result buffered and two columns in flight.
        for (int j = 0; j < 5; j++) begin
            issue_valid = (j == 0) || (j == 2) || (j == 3);
            y_in = (j == 4) ? 16'sd77 : 16'sd0;
            step();
        end
        issue_valid = 1'b0;
        check("t5_before", 32'(out_data), 77);
        #2;
        rst = 1'b1;
        #1;
        check("t5_async_valid", 32'(out_valid), 0);
        check("t5_async_data", 32'(out_data), 0);
        #2;
        rst = 1'b0;
        for (int j = 0; j < 8; j++) begin
            y_in = 16'(j * 1000 + 1);
            step();
            check("t5_no_capture", 32'(out_valid), 0);
        end
        check("t5_can_issue", 32'(can_issue), 1);

        // Alternating issue/idle stream with a toggling consumer.
        exp_q.delete();
        delivered = 0;
        for (int s = 0; s < 60; s++) begin
            issue_valid = (s < 20) && (s % 2 == 0);
            y_in        = ydrv(s);
            out_ready   = (s % 2 == 0);
            if (issue_valid) exp_q.push_back(int'(ydrv(s + DEPTH)));
            #1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("t6_spurious", 1, 0);
                else check("t6_stream", 32'(out_data), 32'(exp_q.pop_front()));
                delivered++;
            end
            step();
            if (s >= 24 && exp_q.size() == 0) break;
        end
        issue_valid = 1'b0;
        out_ready   = 1'b0;
        check("t6_delivered", 32'(delivered), 10);
        check("t6_overflow", 32'(overflow), 0);
        check("t6_empty", 32'(out_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
